// File: rtl/imem_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches on a req/gnt, rvalid bus and
// queues returned {pc, instr} pairs for Fetch, dropping stale responses after a redirect.
module imem_prefetch_buffer #(
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        pop_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fetch_stall_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   req_addr_q, req_addr_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [31:0]   fifo_pc_q[DEPTH];
    logic [31:0]   fifo_pc_d[DEPTH];
    logic [31:0]   fifo_instr_q[DEPTH];
    logic [31:0]   fifo_instr_d[DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] inflight_q, inflight_d;
    logic [OW-1:0] discard_q, discard_d;

    logic        pop_eff;
    logic        grant;
    logic        resp;
    logic        push;
    logic [31:0] credit;
    logic [31:0] redirect_pc_aligned;
    logic        unused_redirect_lsbs;

    assign redirect_pc_aligned  = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    assign instr_valid_o = (count_q != '0);
    assign fetch_stall_o = !instr_valid_o;
    assign instr_o       = fifo_instr_q[rd_ptr_q];
    assign pc_o          = fifo_pc_q[rd_ptr_q];
    assign imem_addr_o   = req_addr_q;

    assign pop_eff = pop_i && instr_valid_o;
    // Live in-flight requests plus buffered entries must always fit in the FIFO.
    assign credit  = 32'(inflight_q) - 32'(discard_q) + 32'(count_q) - 32'(pop_eff);
    assign imem_req_o = !rst && !redirect_i && (32'(inflight_q) < MAX_OUTSTANDING) &&
                        (credit < DEPTH);

    assign grant = imem_req_o && imem_gnt_i;
    assign resp  = imem_rvalid_i && (inflight_q != '0);
    assign push  = resp && (discard_q == '0) && !redirect_i;

    always_comb begin
        req_addr_d   = req_addr_q;
        resp_pc_d    = resp_pc_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop_eff);
        inflight_d   = inflight_q + OW'(grant) - OW'(resp);
        discard_d    = discard_q;

        if (resp && (discard_q != '0)) begin
            discard_d = discard_q - OW'(1);
        end
        if (grant) begin
            req_addr_d = req_addr_q + 32'd4;
        end
        if (push) begin
            fifo_pc_d[wr_ptr_q]    = resp_pc_q;
            fifo_instr_d[wr_ptr_q] = imem_rdata_i;
            wr_ptr_d               = wr_ptr_q + PW'(1);
            resp_pc_d              = resp_pc_q + 32'd4;
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Everything still in flight after this cycle, including this cycle's grant, is stale.
        if (redirect_i) begin
            req_addr_d = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            discard_d  = inflight_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr_q   <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            fifo_pc_q    <= '{default: '0};
            fifo_instr_q <= '{default: '0};
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= '0;
            discard_q    <= '0;
        end else begin
            req_addr_q   <= req_addr_d;
            resp_pc_q    <= resp_pc_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            discard_q    <= discard_d;
        end
    end

    a_no_push_into_full: assert property (@(posedge clk) disable iff (rst)
        push |-> ((count_q != CW'(DEPTH)) || pop_eff));

    a_rvalid_has_request: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid_i |-> (inflight_q != '0));

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Scoreboard bench for imem_prefetch_buffer: stimulus queues expected {pc, instr} pairs,
// a negedge monitor compares every entry Fetch consumes.
module tb_imem_prefetch_buffer;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        pop_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        fetch_stall_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    logic        resp_en;
    logic [31:0] pend_q[$];
    int          pend_n = 0;
    logic [31:0] pend_head = '0;
    int          n_grants = 0;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   base_cyc = 0;
    int   xfer_n = 0;
    int   first_rel = 0;
    int   last_rel = 0;

    imem_prefetch_buffer #(
        .DEPTH          (2),
        .MAX_OUTSTANDING(2),
        .RESET_PC       (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .pop_i        (pop_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .fetch_stall_o(fetch_stall_o),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents differ from the address so pc/instr mix-ups are visible.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // In-order memory: a granted request answers one cycle later unless resp_en holds it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q.delete();
            pend_n    <= 0;
            pend_head <= '0;
        end else begin
            if (imem_rvalid_i) void'(pend_q.pop_front());
            if (imem_req_o && imem_gnt_i) begin
                pend_q.push_back(imem_addr_o);
                n_grants++;
            end
            pend_n    <= pend_q.size();
            pend_head <= (pend_q.size() != 0) ? pend_q[0] : '0;
        end
    end

    assign imem_rvalid_i = resp_en && (pend_n != 0);
    assign imem_rdata_i  = mem_word(pend_head);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%08h, want nothing (t=%0t)", name, act, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (redirect_i) check("req_low_on_redirect", {31'b0, imem_req_o}, 32'd0);
            if (instr_valid_o && pop_i && !redirect_i) begin
                if (xfer_n == 0) first_rel = cyc - base_cyc;
                last_rel = cyc - base_cyc;
                xfer_n++;
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_entry_pc", pc_o);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("head_pc", pc_o, mon_e.pc);
                    check("head_instr", instr_o, mon_e.instr);
                    check("stall_low_when_valid", {31'b0, fetch_stall_o}, 32'd0);
                end
            end
        end
    end

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{pc: start + 32'(4 * i), instr: mem_word(start + 32'(4 * i))});
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        check("rst_stall", {31'b0, fetch_stall_o}, 32'd1);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_addr", imem_addr_o, RESET_PC);
    endtask

    // Leaves rst low from #1 after a rising edge; that cycle is cycle 1.
    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        base_cyc = cyc - 1;
        xfer_n   = 0;
        n_grants = 0;
    endtask

    task automatic do_redirect(input logic [31:0] pc, input logic [31:0] exp_pc, input int n);
        sb_q.delete();
        expect_seq(exp_pc, n);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        base_cyc      = cyc;
        xfer_n        = 0;
        @(posedge clk);
        #1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
    endtask

    task automatic drain(input int bound, input bit keep_pop);
        int k = 0;
        pop_i = 1'b1;
        while (sb_q.size() != 0 && k < bound) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (sb_q.size() != 0) begin
            fail_now("drain_timeout_left", 32'(sb_q.size()));
            sb_q.delete();
        end
        if (!keep_pop) pop_i = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; pop_i = 1'b0;
        imem_gnt_i = 1'b1; resp_en = 1'b1;
        #2;
        check_reset_outputs();

        // Streaming from reset: first entry in cycle 3, then one per cycle.
        expect_seq(RESET_PC, 8);
        pop_i = 1'b1;
        release_reset();
        @(negedge clk);
        check("first_req", {31'b0, imem_req_o}, 32'd1);
        check("first_addr", imem_addr_o, RESET_PC);
        @(posedge clk);
        #1;
        drain(40, 1'b0);
        check("stream_first_cycle", 32'(first_rel), 32'd3);
        check("stream_no_bubbles", 32'(last_rel - first_rel), 32'd7);

        // Fetch stalled: buffer fills to DEPTH and requests stop.
        rst = 1'b1;
        #1;
        release_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_req_off", {31'b0, imem_req_o}, 32'd0);
        check("stall_valid", {31'b0, instr_valid_o}, 32'd1);
        check("stall_grants", 32'(n_grants), 32'd2);
        @(posedge clk);
        #1;
        expect_seq(RESET_PC, 4);
        drain(30, 1'b0);

        // Grant withheld for 3 cycles: request holds at 0x10.
        rst = 1'b1;
        #1;
        expect_seq(RESET_PC, 8);
        pop_i = 1'b1;
        release_reset();
        k = 0;
        while (n_grants < 4 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("grants_before_hold", 32'(n_grants), 32'd4);
        imem_gnt_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("req_held", {31'b0, imem_req_o}, 32'd1);
            check("addr_held", imem_addr_o, 32'h10);
            @(posedge clk);
        end
        #1;
        check("no_grant_while_low", 32'(n_grants), 32'd4);
        imem_gnt_i = 1'b1;
        @(posedge clk);
        #1;
        check("single_grant_after_hold", 32'(n_grants), 32'd5);
        drain(40, 1'b0);

        // Two requests outstanding, then redirect: both responses are dropped.
        settle();
        resp_en = 1'b0;
        pop_i   = 1'b1;
        do_redirect(32'h20, 32'h20, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("req_off_at_max_outstanding", {31'b0, imem_req_o}, 32'd0);
        check("two_outstanding", 32'(pend_n), 32'd2);
        @(posedge clk);
        #1;
        resp_en = 1'b1;
        do_redirect(32'h103, 32'h100, 4);
        drain(40, 1'b0);

        // Redirect landing on a cycle with a grant pending and rvalid high.
        settle();
        pop_i = 1'b1;
        do_redirect(32'h200, 32'h200, 4);
        drain(40, 1'b1);
        do_redirect(32'h400, 32'h400, 6);
        drain(40, 1'b0);
        check("redirect_latency", 32'(first_rel), 32'd3);

        // Reset with two responses in flight.
        settle();
        resp_en = 1'b0;
        do_redirect(32'h300, 32'h300, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        sb_q.delete();
        expect_seq(RESET_PC, 6);
        resp_en = 1'b1;
        pop_i   = 1'b1;
        release_reset();
        drain(40, 1'b0);
        check("restart_latency", 32'(first_rel), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
